// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, R-type funct codes and fetch-stage types.
package mips_pkg;
    localparam int INST_W = 32;
    localparam logic [5:0] FUNCT_ADD = 6'd32;
    localparam logic [5:0] FUNCT_SUB = 6'd34;
    localparam logic [5:0] FUNCT_AND = 6'd36;
    localparam logic [5:0] FUNCT_OR  = 6'd37;
    localparam logic [5:0] FUNCT_SLT = 6'd42;
    typedef enum logic {RUN, HALT} fetch_state_t;
    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/inst_mem.sv
// inst_mem: instruction memory with one write port and a registered read port.
module inst_mem
    import mips_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [INST_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [INST_W-1:0] o_rdata
);
    logic [INST_W-1:0] r_mem [DEPTH];
    logic [INST_W-1:0] r_rdata;
    // Same-address read/write returns the pre-write word.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end
    assign o_rdata = r_rdata;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC sequencing, RUN/HALT control and a 2-entry PC-tagged
// output FIFO in front of the synchronous instruction memory.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_we,
    input  logic [AW-1:0]     load_addr,
    input  logic [INST_W-1:0] load_data,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              inst_ready,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [31:0]       pc_out,
    output logic              halted
);
    localparam logic [31:0] PC_LIM = 32'(DEPTH * 4);
    fetch_state_t      r_state, w_state_next;
    fetch_entry_t      r_fifo [2];
    logic [31:0]       r_pc, r_inflight_pc, w_pc_inc, w_redirect_pc;
    logic [1:0]        r_cnt, w_occ;
    logic              r_inflight, w_pop, w_push, w_issue, w_slot, w_unused;
    logic [INST_W-1:0] w_rdata;

    assign w_pop         = inst_valid && inst_ready;
    // Counting the word leaving this edge keeps the pipe full at one per cycle.
    assign w_occ         = r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
    assign w_issue       = r_state == RUN && !redirect_valid && w_occ < 2'd2;
    assign w_push        = r_inflight && !redirect_valid;
    assign w_slot        = r_cnt[0] ^ w_pop;
    assign w_pc_inc      = r_pc + 32'd4;
    assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
    assign w_unused      = &{1'b0, redirect_pc[1:0]};

    inst_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk     (clk),
        .i_we    (load_we),
        .i_waddr (load_addr),
        .i_wdata (load_data),
        .i_re    (w_issue),
        .i_raddr (r_pc[AW+1:2]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= RUN;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = redirect_valid ? (w_redirect_pc >= PC_LIM ? HALT : RUN)
                     : (w_issue && w_pc_inc >= PC_LIM) ? HALT : r_state;
    end

    always_comb begin
        inst_valid = r_cnt != 2'd0;
        inst       = r_fifo[0].inst;
        pc_out     = r_fifo[0].pc;
        halted     = r_state == HALT && r_cnt == 2'd0 && !r_inflight;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc          <= '0;
            r_cnt         <= '0;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_fifo[0]     <= '0;
            r_fifo[1]     <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_pc;
                r_pc          <= w_pc_inc;
            end
            if (redirect_valid) begin
                r_pc  <= w_redirect_pc;
                r_cnt <= '0;
            end else begin
                if (w_pop) r_fifo[0] <= r_fifo[1];
                if (w_push) r_fifo[w_slot] <= {r_inflight_pc, w_rdata};
                r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scoreboard bench; expected (pc, inst) streams are
// queued on reset/redirect and compared on every transfer.
module tb_instruction_fetch;
    import mips_pkg::*;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam logic [31:0] NEW_WORD = {6'd0, 5'd31, 5'd30, 5'd29, 5'd0, FUNCT_SLT};

    logic clk = 1'b0, rst = 1'b0, load_we = 1'b0, redirect_valid = 1'b0, inst_ready = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [31:0] load_data = '0, redirect_pc = '0;
    logic inst_valid, halted;
    logic [31:0] inst, pc_out;
    logic [31:0] model [DEPTH];
    logic [31:0] last_pc = '1;
    fetch_entry_t q[$];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    instruction_fetch #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .load_we        (load_we),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_ready     (inst_ready),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .pc_out         (pc_out),
        .halted         (halted)
    );

    function automatic void push_stream(input logic [31:0] s);
        for (logic [31:0] p = s; p < 32'(DEPTH * 4); p += 4)
            q.push_back(fetch_entry_t'({p, model[p[AW+1:2]]}));
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            push_stream(32'd0);
        end else begin
            if (inst_valid && inst_ready) begin
                fetch_entry_t e;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra got pc=%h inst=%h, none expected", pc_out, inst);
                end else begin
                    e = q.pop_front();
                    if (pc_out !== e.pc || inst !== e.inst) begin
                        errors++;
                        $display("FAIL sb_xfer got pc=%h inst=%h, need pc=%h inst=%h", pc_out, inst, e.pc, e.inst);
                    end
                end
                last_pc = pc_out;
            end
            if (redirect_valid) begin
                q.delete();
                push_stream({redirect_pc[31:2], 2'b00});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [31:0] t);
        redirect_pc = t;
        redirect_valid = 1'b1;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_halted(input string name);
        int n = 0;
        while (!halted && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (halted !== 1'b1 || inst_valid !== 1'b0 || q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain halted=%b valid=%b pending=%0d, need 1 0 0", name, halted, inst_valid, q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        checks++;
        if ({inst_valid, halted, inst, pc_out} !== 66'd0) begin
            errors++;
            $display("FAIL reset_out valid=%b halted=%b inst=%h pc=%h, need all 0", inst_valid, halted, inst, pc_out);
        end
        inst_ready = 1'b1;
        step();
        rst = 1'b1;
        step();
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_edge1 valid=%b, need 0", inst_valid);
        end
        step();
        checks++;
        if ({inst_valid, pc_out, inst} !== {1'b1, 32'd0, model[0]}) begin
            errors++;
            $display("FAIL reset_edge2 valid=%b pc=%h inst=%h, need 1 0 %h", inst_valid, pc_out, inst, model[0]);
        end
        for (int k = 1; k < 4; k++) begin
            step();
            checks++;
            if ({inst_valid, pc_out} !== {1'b1, 32'(4 * k)}) begin
                errors++;
                $display("FAIL reset_seq valid=%b pc=%h, need 1 %h", inst_valid, pc_out, 4 * k);
            end
        end
        wait_halted("reset");
    endtask

    task automatic test_stall();
        inst_ready = 1'b0;
        redirect(32'd0);
        step();
        step();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({inst_valid, pc_out, inst} !== {1'b1, 32'd0, model[0]}) begin
                errors++;
                $display("FAIL stall_hold valid=%b pc=%h inst=%h, need 1 0 %h", inst_valid, pc_out, inst, model[0]);
            end
            if (k < 3) step();
        end
        inst_ready = 1'b1;
        wait_halted("stall");
    endtask

    task automatic test_redirect();
        inst_ready = 1'b0;
        redirect(32'd0);
        repeat (3) step();
        redirect(32'h6);
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_flush valid=%b, need 0", inst_valid);
        end
        step();
        step();
        checks++;
        if ({inst_valid, pc_out, inst} !== {1'b1, 32'd4, model[1]}) begin
            errors++;
            $display("FAIL redir_first valid=%b pc=%h inst=%h, need 1 4 %h", inst_valid, pc_out, inst, model[1]);
        end
        inst_ready = 1'b1;
        wait_halted("redir6");
        redirect(32'h100);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({halted, inst_valid} !== 2'b10) begin
                errors++;
                $display("FAIL redir_oob halted=%b valid=%b, need 1 0", halted, inst_valid);
            end
            step();
        end
        redirect(32'(DEPTH * 4));
        checks++;
        if ({halted, inst_valid} !== 2'b10) begin
            errors++;
            $display("FAIL redir_limit halted=%b valid=%b, need 1 0", halted, inst_valid);
        end
        redirect(32'(DEPTH * 4 - 4));
        step();
        step();
        checks++;
        if ({inst_valid, pc_out, halted} !== {1'b1, 32'(DEPTH * 4 - 4), 1'b0}) begin
            errors++;
            $display("FAIL redir_last valid=%b pc=%h halted=%b, need 1 %h 0", inst_valid, pc_out, halted, DEPTH * 4 - 4);
        end
        wait_halted("redir_last");
    endtask

    task automatic test_back_to_back();
        inst_ready = 1'b1;
        redirect(32'd0);
        repeat (4) step();
        redirect(32'd8);
        step();
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if ({inst_valid, pc_out} !== {1'b1, 32'(8 + 4 * k)}) begin
                errors++;
                $display("FAIL b2b valid=%b pc=%h, need 1 %h", inst_valid, pc_out, 8 + 4 * k);
            end
        end
        wait_halted("b2b");
    endtask

    task automatic test_halt();
        inst_ready = 1'b1;
        redirect(32'd0);
        repeat (9) step();
        checks++;
        if ({inst_valid, pc_out, halted} !== {1'b1, 32'd28, 1'b0}) begin
            errors++;
            $display("FAIL halt_last valid=%b pc=%h halted=%b, need 1 1c 0", inst_valid, pc_out, halted);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({halted, inst_valid} !== 2'b10 || last_pc !== 32'd28) begin
                errors++;
                $display("FAIL halt_state halted=%b valid=%b last_pc=%h, need 1 0 1c", halted, inst_valid, last_pc);
            end
        end
    endtask

    task automatic test_load_collision();
        inst_ready = 1'b1;
        redirect(32'd0);
        repeat (5) step();
        load_we = 1'b1;
        load_addr = 3'd5;
        load_data = NEW_WORD;
        step();
        load_we = 1'b0;
        model[5] = NEW_WORD;
        wait_halted("collide_old");
        redirect(32'd20);
        step();
        step();
        checks++;
        if ({inst_valid, pc_out, inst} !== {1'b1, 32'd20, NEW_WORD}) begin
            errors++;
            $display("FAIL collide_new valid=%b pc=%h inst=%h, need 1 14 %h", inst_valid, pc_out, inst, NEW_WORD);
        end
        wait_halted("collide_new");
    endtask

    task automatic test_reset_mid();
        inst_ready = 1'b1;
        redirect(32'd0);
        repeat (4) step();
        checks++;
        if (inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL rmid_pre valid=%b, need 1", inst_valid);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({inst_valid, halted, inst, pc_out} !== 66'd0) begin
            errors++;
            $display("FAIL rmid_out valid=%b halted=%b inst=%h pc=%h, need all 0", inst_valid, halted, inst, pc_out);
        end
        step();
        rst = 1'b1;
        step();
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_edge1 valid=%b, need 0", inst_valid);
        end
        step();
        checks++;
        if ({inst_valid, pc_out} !== {1'b1, 32'd0}) begin
            errors++;
            $display("FAIL rmid_edge2 valid=%b pc=%h, need 1 0", inst_valid, pc_out);
        end
        wait_halted("rmid");
    endtask

    initial begin
        logic [5:0] functs [5];
        functs = '{FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_SLT};
        for (int i = 0; i < DEPTH; i++)
            model[i] = {6'd0, 5'(i), 5'(i + 8), 5'(i + 16), 5'd0, functs[i % 5]};
        #12 rst = 1'b1;
        step();
        for (int i = 0; i < DEPTH; i++) begin
            load_we = 1'b1;
            load_addr = AW'(i);
            load_data = model[i];
            step();
        end
        load_we = 1'b0;
        test_reset();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_halt();
        test_load_collision();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
